// File: rtl/shared_tlb_miss_arbiter.sv
// rtl/shared_tlb_miss_arbiter.sv - serialises L1 ITLB/DTLB misses onto the shared TLB and PTW
// Define SHARED_TLB_ARB_RR_EN for round-robin arbitration; default is fixed DTLB-over-ITLB priority.
module shared_tlb_miss_arbiter #(
  parameter int VPN_W  = 27,
  parameter int ASID_W = 16,
  parameter int PTE_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic              itlb_miss_i,
  input  logic              dtlb_miss_i,
  input  logic [VPN_W-1:0]  itlb_vpn_i,
  input  logic [VPN_W-1:0]  dtlb_vpn_i,
  output logic              itlb_gnt_o,
  output logic              dtlb_gnt_o,
  output logic              stlb_req_o,
  output logic [VPN_W-1:0]  stlb_vpn_o,
  output logic [ASID_W-1:0] stlb_asid_o,
  input  logic              stlb_hit_i,
  input  logic [PTE_W-1:0]  stlb_pte_i,
  output logic              ptw_req_o,
  input  logic              ptw_ready_i,
  output logic [VPN_W-1:0]  ptw_vpn_o,
  output logic              ptw_is_instr_o,
  input  logic              ptw_done_i,
  input  logic [PTE_W-1:0]  ptw_pte_i,
  input  logic              ptw_error_i,
  output logic              itlb_resp_valid_o,
  output logic              dtlb_resp_valid_o,
  output logic [PTE_W-1:0]  resp_pte_o,
  output logic              resp_error_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    CHECK     = 3'd2,
    WALK_REQ  = 3'd3,
    WALK_WAIT = 3'd4,
    RESP      = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [VPN_W-1:0]    vpn_q, vpn_d;
  logic [ASID_W-1:0]   asid_q, asid_d;
  logic                is_instr_q, is_instr_d;
  logic [PTE_W-1:0]    pte_q, pte_d;
  logic                err_q, err_d;
  logic                drop_q, drop_d;
  logic                pick_itlb;
  logic                grant_any;

`ifdef SHARED_TLB_ARB_RR_EN
  logic rr_q, rr_d;  // set when ITLB was granted last, so DTLB is favoured next

  assign pick_itlb = itlb_miss_i && (!dtlb_miss_i || !rr_q);

  always_comb begin
    rr_d = rr_q;
    if (grant_any) rr_d = pick_itlb;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= 1'b0;
    else         rr_q <= rr_d;
  end
`else
  assign pick_itlb = itlb_miss_i && !dtlb_miss_i;
`endif

  // Reset gates the combinational grant so every output is low while held in reset.
  assign grant_any  = (state_q == IDLE) && rst_ni && !flush_i && (itlb_miss_i || dtlb_miss_i);
  assign itlb_gnt_o = grant_any && pick_itlb;
  assign dtlb_gnt_o = grant_any && !pick_itlb;

  always_comb begin
    state_d    = state_q;
    vpn_d      = vpn_q;
    asid_d     = asid_q;
    is_instr_d = is_instr_q;
    pte_d      = pte_q;
    err_d      = err_q;
    drop_d     = drop_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d    = LOOKUP;
          vpn_d      = pick_itlb ? itlb_vpn_i : dtlb_vpn_i;
          asid_d     = asid_i;
          is_instr_d = pick_itlb;
        end
      end
      LOOKUP: state_d = flush_i ? IDLE : CHECK;
      CHECK: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (stlb_hit_i) begin
          state_d = RESP;
          pte_d   = stlb_pte_i;
          err_d   = 1'b0;
        end else begin
          state_d = WALK_REQ;
        end
      end
      WALK_REQ: begin
        if (flush_i) drop_d = 1'b1;
        if (ptw_ready_i) state_d = WALK_WAIT;
      end
      WALK_WAIT: begin
        // A walk in flight cannot be aborted; a flush only discards its result.
        if (flush_i) drop_d = 1'b1;
        if (ptw_done_i) begin
          state_d = (drop_q || flush_i) ? IDLE : RESP;
          pte_d   = ptw_pte_i;
          err_d   = ptw_error_i;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) drop_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      vpn_q      <= '0;
      asid_q     <= '0;
      is_instr_q <= 1'b0;
      pte_q      <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vpn_q      <= vpn_d;
      asid_q     <= asid_d;
      is_instr_q <= is_instr_d;
      pte_q      <= pte_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

  assign stlb_req_o        = (state_q == LOOKUP);
  assign stlb_vpn_o        = vpn_q;
  assign stlb_asid_o       = asid_q;
  assign ptw_req_o         = (state_q == WALK_REQ);
  assign ptw_vpn_o         = vpn_q;
  assign ptw_is_instr_o    = is_instr_q;
  assign itlb_resp_valid_o = (state_q == RESP) && !flush_i && is_instr_q;
  assign dtlb_resp_valid_o = (state_q == RESP) && !flush_i && !is_instr_q;
  assign resp_pte_o        = pte_q;
  assign resp_error_o      = err_q;
  assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_shared_tlb_miss_arbiter.sv
// tb/tb_shared_tlb_miss_arbiter.sv - randomized self-checking bench for shared_tlb_miss_arbiter
// Expectations come from a transaction-level model of grant order, latency and response routing.
module tb_shared_tlb_miss_arbiter;
  localparam int VPN_W  = 27;
  localparam int ASID_W = 16;
  localparam int PTE_W  = 64;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic [ASID_W-1:0] asid_i;
  logic              itlb_miss_i, dtlb_miss_i;
  logic [VPN_W-1:0]  itlb_vpn_i, dtlb_vpn_i;
  logic              itlb_gnt_o, dtlb_gnt_o;
  logic              stlb_req_o;
  logic [VPN_W-1:0]  stlb_vpn_o;
  logic [ASID_W-1:0] stlb_asid_o;
  logic              stlb_hit_i;
  logic [PTE_W-1:0]  stlb_pte_i;
  logic              ptw_req_o, ptw_ready_i;
  logic [VPN_W-1:0]  ptw_vpn_o;
  logic              ptw_is_instr_o;
  logic              ptw_done_i;
  logic [PTE_W-1:0]  ptw_pte_i;
  logic              ptw_error_i;
  logic              itlb_resp_valid_o, dtlb_resp_valid_o;
  logic [PTE_W-1:0]  resp_pte_o;
  logic              resp_error_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;

  bit                last_i;
  logic [VPN_W-1:0]  exp_vpn;
  logic [ASID_W-1:0] exp_asid;

  shared_tlb_miss_arbiter #(.VPN_W(VPN_W), .ASID_W(ASID_W), .PTE_W(PTE_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .asid_i(asid_i),
    .itlb_miss_i(itlb_miss_i), .dtlb_miss_i(dtlb_miss_i),
    .itlb_vpn_i(itlb_vpn_i), .dtlb_vpn_i(dtlb_vpn_i),
    .itlb_gnt_o(itlb_gnt_o), .dtlb_gnt_o(dtlb_gnt_o),
    .stlb_req_o(stlb_req_o), .stlb_vpn_o(stlb_vpn_o), .stlb_asid_o(stlb_asid_o),
    .stlb_hit_i(stlb_hit_i), .stlb_pte_i(stlb_pte_i),
    .ptw_req_o(ptw_req_o), .ptw_ready_i(ptw_ready_i), .ptw_vpn_o(ptw_vpn_o),
    .ptw_is_instr_o(ptw_is_instr_o), .ptw_done_i(ptw_done_i),
    .ptw_pte_i(ptw_pte_i), .ptw_error_i(ptw_error_i),
    .itlb_resp_valid_o(itlb_resp_valid_o), .dtlb_resp_valid_o(dtlb_resp_valid_o),
    .resp_pte_o(resp_pte_o), .resp_error_o(resp_error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [142:0] all_outputs();
    return {itlb_gnt_o, dtlb_gnt_o, stlb_req_o, stlb_vpn_o, stlb_asid_o, ptw_req_o,
            ptw_vpn_o, ptw_is_instr_o, itlb_resp_valid_o, dtlb_resp_valid_o,
            resp_pte_o, resp_error_o, busy_o};
  endfunction

  function automatic bit model_pick(input bit ri, input bit rd);
`ifdef SHARED_TLB_ARB_RR_EN
    if (ri && rd) return !last_i;
    return ri;
`else
    return ri && !rd;
`endif
  endfunction

  // Drives a miss in an IDLE cycle and checks which side the model says is granted.
  task automatic start_grant(input bit ri, input bit rd, input logic [VPN_W-1:0] vi,
                             input logic [VPN_W-1:0] vd, output bit side_i);
    bit exp_i;
    exp_i       = model_pick(ri, rd);
    itlb_miss_i = ri;
    dtlb_miss_i = rd;
    itlb_vpn_i  = vi;
    dtlb_vpn_i  = vd;
    asid_i      = ASID_W'($urandom);
    exp_vpn     = exp_i ? vi : vd;
    exp_asid    = asid_i;
    #1;
    checks++;
    if ({itlb_gnt_o, dtlb_gnt_o} !== {exp_i, !exp_i}) begin
      errors++;
      $display("FAIL grant: got itlb_gnt=%b dtlb_gnt=%b, expected itlb_gnt=%b dtlb_gnt=%b",
               itlb_gnt_o, dtlb_gnt_o, exp_i, !exp_i);
    end
    last_i = exp_i;
    side_i = exp_i;
  endtask

  // Acts as shared TLB and PTW for one granted translation, then compares against the model.
  task automatic run_txn(input bit side_i, input bit hold_i, input bit hold_d, input bit hit,
                         input int dr, input int dd, input bit err,
                         input logic [PTE_W-1:0] spte, input logic [PTE_W-1:0] wpte,
                         input int flush_at);
    int c, end_c, stlb_c, ptw_first, ptw_cnt, resp_c, resp_cnt, done_at;
    int resp_cyc, exp_resp_c, exp_last, exp_ptw, exp_first;
    bit prev_req, flushed, r_side_i, r_err;
    logic [PTE_W-1:0] r_pte;
    c = 0; end_c = -1; stlb_c = -1; ptw_first = -1; ptw_cnt = 0;
    resp_c = -1; resp_cnt = 0; done_at = -1; prev_req = 0;
    r_side_i = 0; r_err = 0; r_pte = '0;
    while (end_c < 0 && c < 100) begin
      tick();
      c++;
      flush_i = 0; stlb_hit_i = 0; ptw_ready_i = 0; ptw_done_i = 0; ptw_error_i = 0;
      if (!busy_o) begin
        end_c = c - 1;
      end else begin
        itlb_miss_i = hold_i;
        dtlb_miss_i = hold_d;
        stlb_pte_i  = {$urandom, $urandom};
        ptw_pte_i   = {$urandom, $urandom};
        if (c == flush_at) flush_i = 1;
        if (prev_req) begin
          stlb_hit_i = hit;
          stlb_pte_i = spte;
        end
        prev_req = stlb_req_o;
        if (stlb_req_o) begin
          if (stlb_c < 0) stlb_c = c;
          checks++;
          if (stlb_vpn_o !== exp_vpn || stlb_asid_o !== exp_asid) begin
            errors++;
            $display("FAIL stlb_addr: got vpn=%0h asid=%0h, expected vpn=%0h asid=%0h",
                     stlb_vpn_o, stlb_asid_o, exp_vpn, exp_asid);
          end
        end
        if (ptw_req_o) begin
          if (ptw_first < 0) begin
            ptw_first = c;
            checks++;
            if (ptw_vpn_o !== exp_vpn || ptw_is_instr_o !== side_i) begin
              errors++;
              $display("FAIL ptw_addr: got vpn=%0h is_instr=%b, expected vpn=%0h is_instr=%b",
                       ptw_vpn_o, ptw_is_instr_o, exp_vpn, side_i);
            end
          end
          ptw_cnt++;
          if (ptw_cnt == dr + 1) begin
            ptw_ready_i = 1;
            done_at     = c + 1 + dd;
          end else begin
            ptw_done_i  = 1'($urandom_range(0, 1));
            ptw_error_i = 1'($urandom_range(0, 1));
          end
        end
        if (c == done_at) begin
          ptw_done_i  = 1;
          ptw_pte_i   = wpte;
          ptw_error_i = err;
        end
        #1;
        if (itlb_resp_valid_o || dtlb_resp_valid_o) begin
          resp_cnt++;
          if (resp_c < 0) begin
            resp_c   = c;
            r_side_i = itlb_resp_valid_o;
            r_pte    = resp_pte_o;
            r_err    = resp_error_o;
          end
          if (itlb_resp_valid_o && dtlb_resp_valid_o) resp_cnt++;
        end
      end
    end
    flush_i = 0; stlb_hit_i = 0; ptw_ready_i = 0; ptw_done_i = 0; ptw_error_i = 0;

    resp_cyc   = hit ? 3 : 5 + dr + dd;
    flushed    = (flush_at >= 1) && (flush_at <= resp_cyc);
    exp_resp_c = flushed ? -1 : resp_cyc;
    exp_last   = !flushed ? resp_cyc :
                 (flush_at <= 2 || flush_at == resp_cyc) ? flush_at : resp_cyc - 1;
    exp_ptw    = (hit || (flushed && flush_at <= 2)) ? 0 : dr + 1;
    exp_first  = (exp_ptw == 0) ? -1 : 3;

    checks++;
    if (end_c !== exp_last) begin
      errors++;
      $display("FAIL busy_end: last busy cycle %0d, expected %0d", end_c, exp_last);
    end
    checks++;
    if (stlb_c !== 1) begin
      errors++;
      $display("FAIL stlb_req_cycle: got %0d, expected 1", stlb_c);
    end
    checks++;
    if (ptw_cnt !== exp_ptw || ptw_first !== exp_first) begin
      errors++;
      $display("FAIL ptw_req: got %0d cycles from %0d, expected %0d cycles from %0d",
               ptw_cnt, ptw_first, exp_ptw, exp_first);
    end
    checks++;
    if (resp_c !== exp_resp_c || resp_cnt !== (flushed ? 0 : 1)) begin
      errors++;
      $display("FAIL resp_timing: got cycle %0d count %0d, expected cycle %0d count %0d",
               resp_c, resp_cnt, exp_resp_c, flushed ? 0 : 1);
    end
    if (!flushed && resp_c >= 0) begin
      checks++;
      if (r_side_i !== side_i || r_pte !== (hit ? spte : wpte) || r_err !== (hit ? 1'b0 : err)) begin
        errors++;
        $display("FAIL resp_data: got itlb=%b pte=%0h err=%b, expected itlb=%b pte=%0h err=%b",
                 r_side_i, r_pte, r_err, side_i, hit ? spte : wpte, hit ? 1'b0 : err);
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 0; flush_i = 0; asid_i = '0;
    itlb_miss_i = 1; dtlb_miss_i = 1; itlb_vpn_i = '0; dtlb_vpn_i = '0;
    stlb_hit_i = 0; stlb_pte_i = '0; ptw_ready_i = 0; ptw_done_i = 0;
    ptw_pte_i = '0; ptw_error_i = 0;
    #3;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h, expected 0", all_outputs());
    end
    tick();
    tick();
    itlb_miss_i = 0; dtlb_miss_i = 0;
    rst_ni = 1;
    last_i = 0;
    tick();
  endtask

  task automatic test_itlb_hit();
    bit s;
    start_grant(1, 0, 27'h12345, VPN_W'($urandom), s);
    run_txn(s, 0, 0, 1, 0, 0, 0, 64'hCF, 64'h0, -1);
  endtask

  task automatic test_dtlb_walk_error();
    bit s;
    start_grant(0, 1, VPN_W'($urandom), VPN_W'($urandom), s);
    run_txn(s, 0, 0, 0, 2, 1, 1, 64'h0, {$urandom, $urandom}, -1);
  endtask

  task automatic test_back_to_back_arbitration();
    bit s;
    for (int k = 0; k < 4; k++) begin
      start_grant(1, 1, VPN_W'($urandom), VPN_W'($urandom), s);
      run_txn(s, 1, 1, 1, 0, 0, 0, {$urandom, $urandom}, 64'h0, -1);
    end
    start_grant(1, 0, VPN_W'($urandom), VPN_W'($urandom), s);
    run_txn(s, 0, 0, 1, 0, 0, 0, {$urandom, $urandom}, 64'h0, -1);
  endtask

  task automatic test_flush_check();
    bit s;
    start_grant(1, 0, VPN_W'($urandom), VPN_W'($urandom), s);
    run_txn(s, 0, 0, 1, 0, 0, 0, {$urandom, $urandom}, 64'h0, 2);
  endtask

  task automatic test_flush_walk();
    bit s;
    start_grant(0, 1, VPN_W'($urandom), VPN_W'($urandom), s);
    run_txn(s, 0, 0, 0, 1, 3, 0, 64'h0, {$urandom, $urandom}, 6);
    start_grant(1, 0, VPN_W'($urandom), VPN_W'($urandom), s);
    run_txn(s, 0, 0, 0, 0, 1, 0, 64'h0, {$urandom, $urandom}, -1);
  endtask

  task automatic test_reset_in_walk();
    bit s;
    start_grant(1, 0, VPN_W'($urandom), VPN_W'($urandom), s);
    tick(); itlb_miss_i = 0;
    tick();
    tick(); ptw_ready_i = 1;
    checks++;
    if (ptw_req_o !== 1'b1) begin
      errors++;
      $display("FAIL walk_setup: got ptw_req_o=%b, expected 1", ptw_req_o);
    end
    tick(); ptw_ready_i = 0; itlb_miss_i = 1;
    rst_ni = 0;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL reset_in_walk: got %0h, expected 0", all_outputs());
    end
    tick();
    rst_ni = 1;
    last_i = 0;
    start_grant(1, 0, itlb_vpn_i, VPN_W'($urandom), s);
    run_txn(s, 0, 0, 1, 0, 0, 0, {$urandom, $urandom}, 64'h0, -1);
  endtask

  task automatic test_random();
    bit s, ri, rd, hit;
    int dr, dd, fa, rc;
    for (int k = 0; k < 40; k++) begin
      ri = 1'($urandom_range(0, 1));
      rd = ri ? 1'($urandom_range(0, 1)) : 1'b1;
      hit = 1'($urandom_range(0, 1));
      dr = $urandom_range(0, 3);
      dd = $urandom_range(0, 3);
      rc = hit ? 3 : 5 + dr + dd;
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rc) : -1;
      start_grant(ri, rd, VPN_W'($urandom), VPN_W'($urandom), s);
      run_txn(s, 0, 0, hit, dr, dd, 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, {$urandom, $urandom}, fa);
    end
  endtask

  initial begin
    test_reset();
    test_itlb_hit();
    test_dtlb_walk_error();
    test_back_to_back_arbitration();
    test_flush_check();
    test_flush_walk();
    test_reset_in_walk();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_tlb_miss_arbiter.md
# shared_tlb_miss_arbiter

Arbitrates L1 ITLB and DTLB misses onto the single shared TLB and page-table walker (PTW) in the CVA6 MMU. It serialises one translation at a time: grant, shared-TLB lookup, PTW walk on a shared miss, then a response routed back to the originating L1 TLB. It sits between the two 2-entry L1 TLBs and the 64-entry shared TLB / PTW pair, and is instantiated only when the MMU and shared TLB are present.

## Interface
- VPN_W, 27, virtual page number width (Sv39)
- ASID_W, 16, address-space ID width
- PTE_W, 64, page-table entry width

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  sfence.vma / TLB flush pulse
- asid_i  in  ASID_W  current ASID, sampled at grant
- itlb_miss_i / dtlb_miss_i  in  1  miss request, held until grant
- itlb_vpn_i / dtlb_vpn_i  in  VPN_W  miss VPN
- itlb_gnt_o / dtlb_gnt_o  out  1  one-cycle grant pulse
- stlb_req_o  out  1  shared-TLB lookup strobe
- stlb_vpn_o  out  VPN_W  latched VPN
- stlb_asid_o  out  ASID_W  latched ASID
- stlb_hit_i  in  1  lookup hit, valid the cycle after stlb_req_o
- stlb_pte_i  in  PTE_W  PTE on hit
- ptw_req_o  out  1  walk request, held until ptw_ready_i
- ptw_ready_i  in  1  PTW accepts request
- ptw_vpn_o  out  VPN_W  latched VPN
- ptw_is_instr_o  out  1  walk is for instruction side
- ptw_done_i  in  1  walk complete pulse
- ptw_pte_i  in  PTE_W  walked PTE
- ptw_error_i  in  1  walk fault, qualified by ptw_done_i
- itlb_resp_valid_o / dtlb_resp_valid_o  out  1  one-cycle response pulse
- resp_pte_o  out  PTE_W  response PTE
- resp_error_o  out  1  response is a fault
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, LOOKUP, CHECK, WALK_REQ, WALK_WAIT, RESP.
- IDLE: if any miss_i is high and flush_i is low, grant one requester; latch VPN, ASID, side; go to LOOKUP. Grant is combinational in IDLE.
- LOOKUP: stlb_req_o=1 → CHECK.
- CHECK: stlb_hit_i=1 → latch stlb_pte_i, error=0 → RESP; else → WALK_REQ.
- WALK_REQ: ptw_req_o=1 until ptw_ready_i; on handshake → WALK_WAIT.
- WALK_WAIT: on ptw_done_i latch ptw_pte_i and ptw_error_i → RESP, or → IDLE silently if the drop flag is set.
- RESP: pulse the resp_valid of the latched side with resp_pte_o/resp_error_o → IDLE.
- flush_i in LOOKUP/CHECK/RESP: → IDLE, no response. In WALK_REQ/WALK_WAIT: set the drop flag. The walk is never aborted; the request is still issued if pending. The flag clears on return to IDLE.
- flush_i in IDLE suppresses grant that cycle.
- A requester that deasserts miss_i after grant has no effect; its response is still delivered.

## Timing
- Reset: all outputs 0; state IDLE; latches 0; drop flag 0; RR pointer selects ITLB.
- Shared-TLB hit: grant in cycle N, stlb_req_o in N+1, hit sampled in N+2, resp_valid in N+3.
- Miss: ptw_req_o first asserted in N+3. resp_valid follows the cycle after ptw_done_i.
- Back-to-back: next grant is possible in the cycle after RESP.
- ptw_done_i outside WALK_WAIT is ignored.

## Configuration
- SHARED_TLB_ARB_RR_EN defined: round-robin arbitration. A 1-bit pointer favours the side not granted last. It updates on every grant. On simultaneous misses, grants alternate.
- Undefined: fixed priority, DTLB over ITLB. No pointer flop.

## Test plan
- ITLB miss vpn=0x12345, stlb_hit_i=1, pte=0xCF → itlb_gnt_o at N, itlb_resp_valid_o at N+3, resp_pte_o=0xCF, resp_error_o=0.
- DTLB miss, shared miss, ptw_ready_i delayed 2 cycles, ptw_done_i with error=1 → ptw_is_instr_o=0; ptw_req_o held 3 cycles; dtlb_resp_valid_o with resp_error_o=1.
- Both misses held continuously for 4 translations → with RR_EN, grant order I,D,I,D; without it, D is granted first and I only after D drops.
- flush_i during WALK_WAIT, then ptw_done_i → no resp_valid; busy_o falls the cycle after done.
- flush_i in CHECK → IDLE next cycle, no ptw_req_o, no response.
- rst_ni asserted in WALK_WAIT → all outputs 0 immediately; after release, a pending miss is granted on the first clock edge.
